// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } if_id_t;

    // Branch/jump targets are forced onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/instruction_fetch_if_id_register.sv
// IF/ID pipeline register: bubble beats load, otherwise holds.
module if_id_register
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   bubble,
    input  if_id_t data,
    output if_id_t q
);

    // A bubble only clears instr/valid; pc4 is left stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (bubble) begin
            q.instr <= NOP_INSTR;
            q.valid <= 1'b0;
        end else if (load) begin
            q <= data;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC, next-PC selection, imem req/ready handshake,
// stall skid buffer and wrong-path response drain.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stallInput,
    input  logic            jumpInput,
    input  logic [XLEN-1:0] pcJumpInput,
    input  logic            branchTakenInput,
    input  logic [XLEN-1:0] pcBranchInput,
    output logic            imemReqOutput,
    output logic [XLEN-1:0] imemAddrOutput,
    input  logic            imemReadyInput,
    input  logic [XLEN-1:0] imemDataInput,
    output logic [XLEN-1:0] instructionOutput,
    output logic [XLEN-1:0] pc4Output,
    output logic            validOutput
);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next, pc_plus4;
    logic [XLEN-1:0] skid_instr, skid_instr_next;
    logic [XLEN-1:0] skid_pc4, skid_pc4_next;
    logic [XLEN-1:0] target, target_next;
    logic [XLEN-1:0] branch_target, jump_target, redirect_target;
    logic            redirect;
    logic            ifid_load, ifid_bubble;
    if_id_t          ifid_data, ifid_q;

    assign pc_plus4        = pc + XLEN'(4);
    assign branch_target   = word_align(pcBranchInput);
    assign jump_target     = word_align(pcJumpInput);
    // Branch overrides stall; a jump needs a real IF/ID instruction and no stall.
    assign redirect        = branchTakenInput || (!stallInput && jumpInput && ifid_q.valid);
    assign redirect_target = branchTakenInput ? branch_target : jump_target;

    // Next-state, next-PC and IF/ID control.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        skid_instr_next = skid_instr;
        skid_pc4_next   = skid_pc4;
        target_next     = target;
        ifid_load       = 1'b0;
        ifid_bubble     = 1'b0;
        ifid_data       = '{instr: imemDataInput, pc4: pc_plus4, valid: 1'b1};
        case (state)
            FETCH: begin
                if (redirect) begin
                    ifid_bubble = 1'b1;
                    if (imemReadyInput) begin
                        pc_next = redirect_target;
                    end else begin
                        // Address must stay put until the outstanding read retires.
                        target_next = redirect_target;
                        state_next  = DRAIN;
                    end
                end else if (stallInput) begin
                    if (imemReadyInput) begin
                        skid_instr_next = imemDataInput;
                        skid_pc4_next   = pc_plus4;
                        state_next      = HOLD;
                    end
                end else if (imemReadyInput) begin
                    ifid_load = 1'b1;
                    pc_next   = pc_plus4;
                end else begin
                    ifid_bubble = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    ifid_bubble = 1'b1;
                    pc_next     = redirect_target;
                    state_next  = FETCH;
                end else if (!stallInput) begin
                    ifid_load  = 1'b1;
                    ifid_data  = '{instr: skid_instr, pc4: skid_pc4, valid: 1'b1};
                    pc_next    = pc_plus4;
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                ifid_bubble = 1'b1;
                if (imemReadyInput) begin
                    pc_next    = branchTakenInput ? branch_target : target;
                    state_next = FETCH;
                end else if (branchTakenInput) begin
                    target_next = branch_target;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            skid_instr <= '0;
            skid_pc4   <= '0;
            target     <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            skid_instr <= skid_instr_next;
            skid_pc4   <= skid_pc4_next;
            target     <= target_next;
        end
    end

    if_id_register u_if_id (
        .clk    (clk),
        .reset  (reset),
        .load   (ifid_load),
        .bubble (ifid_bubble),
        .data   (ifid_data),
        .q      (ifid_q)
    );

    // Request must be live in the first cycle after reset drops, so it is decoded from state.
    assign imemReqOutput     = !reset && (state != HOLD);
    assign imemAddrOutput    = pc;
    assign instructionOutput = ifid_q.instr;
    assign pc4Output         = ifid_q.pc4;
    assign validOutput       = ifid_q.valid;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the 5-stage MIPS pipeline, directly upstream of instruction decode. Holds the PC, issues word reads to instruction memory over a req/ready handshake, and selects the next PC from sequential, jump, and taken-branch sources. Owns the IF/ID pipeline register, with stall (hold), squash (bubble) and in-flight-fetch discard on redirect.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; word aligned.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- stallInput  in  1  load-use hazard from decode; freeze PC and IF/ID.
- jumpInput  in  1  jump decoded from the IF/ID instruction.
- pcJumpInput  in  32  jump target.
- branchTakenInput  in  1  taken branch resolved in execute.
- pcBranchInput  in  32  branch target.
- imemReqOutput  out  1  read request.
- imemAddrOutput  out  32  byte address; always equals PC.
- imemReadyInput  in  1  read data valid this cycle; combinational same-cycle response allowed.
- imemDataInput  in  32  instruction word.
- instructionOutput  out  32  IF/ID instruction; 0 (NOP) when bubble.
- pc4Output  out  32  IF/ID PC+4.
- validOutput  out  1  IF/ID holds a real instruction.

## Operation
- States: FETCH, HOLD, DRAIN.
  - FETCH: imemReqOutput=1, addr=PC.
  - HOLD: req=0; fetched word parked in skid buffer.
  - DRAIN: req=1; waiting to discard a wrong-path response.
- Redirect priority: branchTakenInput > stallInput > jumpInput (jump honoured only when validOutput=1) > sequential.
- No delay slots. Targets forced word aligned (bits [1:0] cleared).
- Accept: FETCH & imemReadyInput & no redirect & no stall.
  - IF/ID <= {imemDataInput, PC+4, valid=1}.
  - PC <= PC+4.
- Stall in FETCH with ready:
  - IF/ID holds.
  - Word and PC+4 go into skid buffer; state -> HOLD.
  - PC unchanged.
- Stall in FETCH without ready: IF/ID holds; request stays pending.
- HOLD, stall released: IF/ID <= buffer; PC <= PC+4; state -> FETCH.
- Branch taken, any state:
  - IF/ID <= bubble (instr=0, valid=0; pc4Output may hold stale value).
  - Skid buffer invalidated.
  - Overrides stall.
- Jump (not stalled): IF/ID <= bubble; concurrently fetched word discarded.
- Redirect target T, with ready high in FETCH or while in HOLD: PC <= T; state -> FETCH.
- Redirect target T, in FETCH with ready low: address must stay stable.
  - Save T; state -> DRAIN.
  - In DRAIN, on ready: discard data, PC <= saved T, state -> FETCH.
  - A newer branch during DRAIN overwrites the saved target (latest wins).
- PC+4 wraps modulo 2^32.

## Timing
- Reset (sync, overrides everything):
  - PC=RESET_PC, state=FETCH.
  - instructionOutput=0, pc4Output=0, validOutput=0.
  - Skid buffer and saved target invalid.
  - imemReqOutput=0 in the reset cycle; req asserted in the first cycle after reset deasserts.
- Reset mid-DRAIN/HOLD: pending response ignored; the memory must tolerate the request being dropped.
- Zero-wait memory: one instruction per cycle. Req-to-IF/ID latency = 1 edge after the ready cycle.
- N wait cycles: IF/ID valid N+1 cycles after req asserts.
- Redirect penalty, zero-wait memory:
  - Jump: 1 bubble.
  - Branch: 2 bubbles (the IF/ID entry and the in-flight fetch).
  - Target requested the cycle after the redirect.
- Simultaneous stall + branch: branch wins, IF/ID bubble.
- Simultaneous stall + jump: stall wins, jump re-evaluated next cycle.

## Structure
- Package fetch_pkg:
  - typedef enum fetch_state_t {FETCH, HOLD, DRAIN}.
  - NOP_INSTR = 32'h0.
  - Default RESET_PC.
- Sub-module if_id_register:
  - Inputs: load, bubble, data.
  - Bubble beats load; hold otherwise.
- FSM, PC, skid buffer and next-PC mux live in instruction_fetch.

## Test plan
- Reset, zero-wait memory returning word = addr: after release, IF/ID shows instr 0,4,8 with pc4 4,8,12 on consecutive cycles; valid=1 from the 2nd cycle.
- 3-cycle wait memory: addr 0 held stable for all 4 req cycles; IF/ID valid 1 cycle after ready.
- stallInput 2 cycles while ready: IF/ID frozen; req low in HOLD; after release the buffered word appears, then fetch resumes at PC+4, with no loss or duplication.
- jumpInput with pcJumpInput=32'h40 while IF/ID valid: next IF/ID is a bubble; next request addr=0x40; then instr 0x40 valid.
- branchTakenInput, pcBranchInput=32'h100, with a fetch pending (ready low): state DRAIN, addr unchanged until ready; data discarded; then req addr=0x100.
- branchTakenInput during stall, and reset during DRAIN: bubble and redirect win; reset returns all outputs to reset values and PC=RESET_PC.
